// File: rtl/i2c_av_pkg.sv
// Shared types and constants for the audio-codec I2C command path.
package i2c_av_pkg;

    localparam int unsigned I2C_W      = 24;
    localparam logic        ACK_OK     = 1'b0;
    localparam logic [7:0]  CODEC_ADDR = 8'h34;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_START,
        ST_WAIT_END,
        ST_CHECK,
        ST_GAP,
        ST_RELEASE
    } arbState_t;

    typedef struct packed {
        logic [7:0] slave;
        logic [7:0] sub;
        logic [7:0] data;
    } i2cWord_t;

endpackage

// File: rtl/i2c_cmd_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping at NREQ-1.
module rr_pick #(
    parameter  int unsigned NREQ = 3,
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int unsigned cand;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!valid && req[IW'(cand)]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
        grant[idx] = valid;
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C write engine between NREQ requesters with round-robin grant,
// NACK/timeout retry and per-requester done/error reporting; advances only on iTICK.
module i2c_cmd_arbiter
    import i2c_av_pkg::*;
#(
    parameter int unsigned NREQ          = 3,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iTICK,
    input  logic [NREQ-1:0]         iREQ,
    input  logic [NREQ*I2C_W-1:0]   iDATA,
    output logic [NREQ-1:0]         oGRANT,
    output logic [NREQ-1:0]         oDONE,
    output logic                    oERR,
    output logic                    oBUSY,
    output logic [I2C_W-1:0]        oI2C_DATA,
    output logic                    oI2C_GO,
    input  logic                    iI2C_END,
    input  logic                    iI2C_ACK
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned RW = 4;
    localparam int unsigned TW = 8;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NREQ - 1);

    arbState_t       state;
    logic [IW-1:0]   rrPtr;
    logic [IW-1:0]   grantIdx;
    logic [RW-1:0]   retryCnt;
    logic [TW-1:0]   tmoCnt;
    logic            timedOut;

    logic [NREQ-1:0] pickGrant;
    logic [IW-1:0]   pickIdx;
    logic            pickValid;
    i2cWord_t        reqWord [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : gSlice
        assign reqWord[gi] = iDATA[gi*I2C_W +: I2C_W];
    end

    rr_pick #(.NREQ(NREQ)) uPick (
        .req   (iREQ),
        .ptr   (rrPtr),
        .grant (pickGrant),
        .idx   (pickIdx),
        .valid (pickValid)
    );

    // Arbitration/transfer FSM; oDONE/oERR default low so they pulse for one iCLK cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_IDLE;
            rrPtr     <= '0;
            grantIdx  <= '0;
            retryCnt  <= '0;
            tmoCnt    <= '0;
            timedOut  <= 1'b0;
            oGRANT    <= '0;
            oDONE     <= '0;
            oERR      <= 1'b0;
            oBUSY     <= 1'b0;
            oI2C_DATA <= '0;
            oI2C_GO   <= 1'b0;
        end else begin
            oDONE <= '0;
            oERR  <= 1'b0;
            if (iTICK) begin
                case (state)
                    ST_IDLE: begin
                        if (pickValid) begin
                            oGRANT   <= pickGrant;
                            grantIdx <= pickIdx;
                            retryCnt <= '0;
                            oBUSY    <= 1'b1;
                            state    <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        oI2C_DATA <= reqWord[grantIdx];
                        oI2C_GO   <= 1'b1;
                        tmoCnt    <= '0;
                        timedOut  <= 1'b0;
                        state     <= ST_WAIT_START;
                    end
                    ST_WAIT_START: begin
                        if (!iI2C_END) begin
                            state <= ST_WAIT_END;
                        end else if (tmoCnt == TMO_LAST) begin
                            oI2C_GO  <= 1'b0;
                            timedOut <= 1'b1;
                            state    <= ST_CHECK;
                        end else begin
                            tmoCnt <= tmoCnt + TW'(1);
                        end
                    end
                    ST_WAIT_END: begin
                        if (iI2C_END) begin
                            oI2C_GO <= 1'b0;
                            state   <= ST_CHECK;
                        end else if (tmoCnt == TMO_LAST) begin
                            oI2C_GO  <= 1'b0;
                            timedOut <= 1'b1;
                            state    <= ST_CHECK;
                        end else begin
                            tmoCnt <= tmoCnt + TW'(1);
                        end
                    end
                    ST_CHECK: begin
                        if ((iI2C_ACK == ACK_OK) && !timedOut) begin
                            oDONE <= oGRANT;
                            oERR  <= 1'b0;
                            state <= ST_RELEASE;
                        end else if (retryCnt < RETRY_MAX) begin
                            retryCnt <= retryCnt + RW'(1);
                            state    <= ST_GAP;
                        end else begin
                            oDONE <= oGRANT;
                            oERR  <= 1'b1;
                            state <= ST_RELEASE;
                        end
                    end
                    // GO already low; hold it one more tick so the controller re-arms.
                    ST_GAP: begin
                        state <= ST_LOAD;
                    end
                    ST_RELEASE: begin
                        oGRANT <= '0;
                        rrPtr  <= (grantIdx == IDX_LAST) ? '0 : grantIdx + IW'(1);
                        oBUSY  <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter with a behavioural I2C controller model.
module tb_i2c_cmd_arbiter;
    import i2c_av_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned W    = I2C_W;

    typedef struct { int idx; bit err; } doneExp_t;

    logic            iCLK   = 1'b0;
    logic            iRST_N = 1'b0;
    logic            iTICK  = 1'b0;
    logic            mdlRstN = 1'b0;
    logic [NREQ-1:0] iREQ   = '0;
    logic [NREQ*W-1:0] iDATA;
    logic [W-1:0]    reqData [NREQ];
    logic [NREQ-1:0] oGRANT, oDONE;
    logic            oERR, oBUSY, oI2C_GO;
    logic [W-1:0]    oI2C_DATA;
    logic            i2cEnd, i2cAck;

    int nCompared   = 0;
    int nMismatched = 0;
    int       expGrant [$];
    doneExp_t expDone  [$];

    i2c_cmd_arbiter #(.NREQ(NREQ), .MAX_RETRY(3), .TIMEOUT_TICKS(64)) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iTICK     (iTICK),
        .iREQ      (iREQ),
        .iDATA     (iDATA),
        .oGRANT    (oGRANT),
        .oDONE     (oDONE),
        .oERR      (oERR),
        .oBUSY     (oBUSY),
        .oI2C_DATA (oI2C_DATA),
        .oI2C_GO   (oI2C_GO),
        .iI2C_END  (i2cEnd),
        .iI2C_ACK  (i2cAck)
    );

    for (genvar g = 0; g < NREQ; g++) begin : gData
        assign iDATA[g*W +: W] = reqData[g];
    end

    always #5 iCLK = ~iCLK;

    // One-cycle tick every 4 clocks.
    int unsigned div = 0;
    always @(posedge iCLK) begin
        div   <= (div == 3) ? 0 : div + 1;
        iTICK <= (div == 2);
    end

    // Controller model: END drops one clock after GO, stays low endTicks ticks, then scripted ACK.
    int endTicks = 27;
    bit hangMode = 1'b0;
    bit ackScript [32];
    int ackWr = 0;
    int ackRd = 0;
    bit armed;
    bit mdlBusy;
    int mdlCnt;
    always @(posedge iCLK or negedge mdlRstN) begin
        if (!mdlRstN) begin
            i2cEnd  <= 1'b1;
            i2cAck  <= 1'b0;
            armed   <= 1'b1;
            mdlBusy <= 1'b0;
            mdlCnt  <= 0;
        end else begin
            if (!oI2C_GO) armed <= 1'b1;
            if (!mdlBusy && armed && oI2C_GO && !hangMode) begin
                i2cEnd  <= 1'b0;
                mdlBusy <= 1'b1;
                armed   <= 1'b0;
                mdlCnt  <= endTicks;
            end else if (mdlBusy && iTICK) begin
                if (mdlCnt <= 1) begin
                    i2cEnd  <= 1'b1;
                    mdlBusy <= 1'b0;
                    i2cAck  <= (ackRd < ackWr) ? ackScript[ackRd % 32] : 1'b0;
                    if (ackRd < ackWr) ackRd <= ackRd + 1;
                end else begin
                    mdlCnt <= mdlCnt - 1;
                end
            end
        end
    end

    // Output monitor: scoreboard pops on grant/done, plus tick statistics.
    logic            goPrev = 1'b0, busyPrev = 1'b0;
    logic [NREQ-1:0] grantPrev = '0, donePrev = '0, expVec;
    int  curIdx = 0, goPulses = 0, goTicks = 0, lastGoTicks = 0, gapTicks = 0;
    int  retryRises = 0, shortRetryGaps = 0, grantTicks = 0, lastGrantTicks = 0;
    int  busyLow = 0, busyGapOne = 0, busyGapOther = 0, doneCnt = 0;
    bit  pulseInGrant = 1'b0;
    doneExp_t de;
    always @(negedge iCLK) begin
        if (oGRANT != '0 && grantPrev == '0) begin
            grantTicks   = 0;
            pulseInGrant = 1'b0;
            nCompared++;
            if (!$onehot(oGRANT)) begin
                nMismatched++;
                $display("FAIL grant_onehot: got %b, need exactly one bit", oGRANT);
            end
            nCompared++;
            if (expGrant.size() == 0) begin
                nMismatched++;
                $display("FAIL grant_order: got %b, no grant expected", oGRANT);
            end else begin
                curIdx = expGrant.pop_front();
                expVec = NREQ'(1) << curIdx;
                if (oGRANT !== expVec) begin
                    nMismatched++;
                    $display("FAIL grant_order: got %b, expected %b", oGRANT, expVec);
                end
            end
        end
        if (oGRANT == '0 && grantPrev != '0) lastGrantTicks = grantTicks;
        if (oI2C_GO && !goPrev) begin
            goPulses++;
            if (pulseInGrant) begin
                retryRises++;
                if (gapTicks < 1) shortRetryGaps++;
            end
            pulseInGrant = 1'b1;
            goTicks = 0;
            nCompared++;
            if (oI2C_DATA !== reqData[curIdx]) begin
                nMismatched++;
                $display("FAIL i2c_data: got %h, expected %h", oI2C_DATA, reqData[curIdx]);
            end
        end
        if (!oI2C_GO && goPrev) begin
            lastGoTicks = goTicks;
            gapTicks    = 0;
        end
        if (oBUSY && !busyPrev) begin
            if (busyLow == 1) busyGapOne++;
            else busyGapOther++;
        end
        if (!oBUSY && busyPrev) busyLow = 0;
        if (oDONE != '0 && donePrev == '0) begin
            doneCnt++;
            nCompared++;
            if (expDone.size() == 0) begin
                nMismatched++;
                $display("FAIL done_event: got done=%b err=%b, none expected", oDONE, oERR);
            end else begin
                de     = expDone.pop_front();
                expVec = NREQ'(1) << de.idx;
                if (oDONE !== expVec || oERR !== de.err) begin
                    nMismatched++;
                    $display("FAIL done_event: got done=%b err=%b, expected done=%b err=%b",
                             oDONE, oERR, expVec, de.err);
                end
            end
        end
        if (donePrev != '0) begin
            nCompared++;
            if (oDONE !== '0) begin
                nMismatched++;
                $display("FAIL done_width: got %b one cycle after pulse, expected 0", oDONE);
            end
        end
        if (iTICK) begin
            if (oI2C_GO) goTicks++;
            else gapTicks++;
            if (oGRANT != '0) grantTicks++;
            if (!oBUSY) busyLow++;
        end
        goPrev    = oI2C_GO;
        busyPrev  = oBUSY;
        grantPrev = oGRANT;
        donePrev  = oDONE;
    end

    task automatic run_until(input int target, input int budget, input bit drop, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge iCLK);
            n++;
            if (drop) begin
                for (int i = 0; i < NREQ; i++) if (oDONE[i]) iREQ[i] = 1'b0;
            end
            if (doneCnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b0; mdlRstN = 1'b0;
        repeat (3) @(negedge iCLK);
        nCompared += 6;
        if (oGRANT !== '0)    begin nMismatched++; $display("FAIL rst_grant: got %b, expected 0", oGRANT); end
        if (oDONE !== '0)     begin nMismatched++; $display("FAIL rst_done: got %b, expected 0", oDONE); end
        if (oERR !== 1'b0)    begin nMismatched++; $display("FAIL rst_err: got %b, expected 0", oERR); end
        if (oBUSY !== 1'b0)   begin nMismatched++; $display("FAIL rst_busy: got %b, expected 0", oBUSY); end
        if (oI2C_DATA !== '0) begin nMismatched++; $display("FAIL rst_data: got %h, expected 0", oI2C_DATA); end
        if (oI2C_GO !== 1'b0) begin nMismatched++; $display("FAIL rst_go: got %b, expected 0", oI2C_GO); end
        iRST_N = 1'b1; mdlRstN = 1'b1;
        repeat (20) @(negedge iCLK);
        nCompared++;
        if (oBUSY !== 1'b0 || oGRANT !== '0) begin
            nMismatched++;
            $display("FAIL idle_no_req: busy=%b grant=%b, expected 0/0", oBUSY, oGRANT);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int b1 = busyGapOne, b2 = busyGapOther;
        reqData[0] = 24'h34_0010; reqData[1] = 24'h34_0A17; reqData[2] = 24'h34_0C5A;
        endTicks = 3;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                expGrant.push_back(i);
                expDone.push_back('{i, 1'b0});
            end
        end
        iREQ = '1;
        run_until(doneCnt + 6, 600, 1'b0, ok);
        iREQ = '0;
        repeat (16) @(negedge iCLK);
        nCompared += 4;
        if (!ok) begin nMismatched++; $display("FAIL rr_timeout: got %0d dones, expected 6", doneCnt); end
        if (busyGapOne - b1 != 5) begin
            nMismatched++; $display("FAIL rr_busy_gap: got %0d one-tick gaps, expected 5", busyGapOne - b1);
        end
        if (busyGapOther - b2 != 1) begin
            nMismatched++; $display("FAIL rr_busy_other: got %0d other gaps, expected 1", busyGapOther - b2);
        end
        if (expGrant.size() != 0) begin
            nMismatched++; $display("FAIL rr_grants_left: got %0d pending, expected 0", expGrant.size());
        end
    endtask

    task automatic test_single();
        bit ok;
        reqData[0] = 24'h34_1201;
        endTicks = 27;
        expGrant.push_back(0);
        expDone.push_back('{0, 1'b0});
        iREQ[0] = 1'b1;
        run_until(doneCnt + 1, 400, 1'b1, ok);
        repeat (12) @(negedge iCLK);
        nCompared += 4;
        if (!ok) begin nMismatched++; $display("FAIL single_timeout: no done, expected one"); end
        if (lastGoTicks != 28) begin
            nMismatched++; $display("FAIL single_go_ticks: got %0d, expected 28", lastGoTicks);
        end
        // Grant spans LOAD..RELEASE; the IDLE decision tick adds one.
        if (lastGrantTicks + 1 != 32) begin
            nMismatched++; $display("FAIL single_total_ticks: got %0d, expected 32", lastGrantTicks + 1);
        end
        if (oBUSY !== 1'b0 || oI2C_GO !== 1'b0) begin
            nMismatched++; $display("FAIL single_after: busy=%b go=%b, expected 0/0", oBUSY, oI2C_GO);
        end
    endtask

    task automatic test_nack_retry();
        bit ok;
        int p = goPulses, r = retryRises, s = shortRetryGaps;
        reqData[1] = 24'h34_0E3C;
        endTicks = 5;
        ackScript[ackWr % 32] = 1'b1; ackWr++;
        ackScript[ackWr % 32] = 1'b1; ackWr++;
        ackScript[ackWr % 32] = 1'b0; ackWr++;
        expGrant.push_back(1);
        expDone.push_back('{1, 1'b0});
        iREQ[1] = 1'b1;
        run_until(doneCnt + 1, 800, 1'b1, ok);
        repeat (12) @(negedge iCLK);
        nCompared += 4;
        if (!ok) begin nMismatched++; $display("FAIL nack_timeout: no done, expected one"); end
        if (goPulses - p != 3) begin
            nMismatched++; $display("FAIL nack_go_pulses: got %0d, expected 3", goPulses - p);
        end
        if (retryRises - r != 2) begin
            nMismatched++; $display("FAIL nack_retries: got %0d, expected 2", retryRises - r);
        end
        if (shortRetryGaps - s != 0) begin
            nMismatched++; $display("FAIL nack_go_gap: got %0d gaps under 1 tick, expected 0", shortRetryGaps - s);
        end
    endtask

    task automatic test_retry_exhaust();
        bit ok;
        int p = goPulses;
        reqData[2] = 24'h34_0800;
        endTicks = 4;
        for (int i = 0; i < 4; i++) begin ackScript[ackWr % 32] = 1'b1; ackWr++; end
        ackScript[ackWr % 32] = 1'b0; ackWr++;
        expGrant.push_back(2);
        expDone.push_back('{2, 1'b1});
        iREQ[2] = 1'b1;
        run_until(doneCnt + 1, 800, 1'b1, ok);
        repeat (12) @(negedge iCLK);
        nCompared += 2;
        if (!ok) begin nMismatched++; $display("FAIL exhaust_timeout: no done, expected one"); end
        if (goPulses - p != 4) begin
            nMismatched++; $display("FAIL exhaust_go_pulses: got %0d, expected 4", goPulses - p);
        end
        p = goPulses;
        reqData[0] = 24'h34_0A80;
        expGrant.push_back(0);
        expDone.push_back('{0, 1'b0});
        iREQ[0] = 1'b1;
        run_until(doneCnt + 1, 400, 1'b1, ok);
        repeat (12) @(negedge iCLK);
        nCompared += 2;
        if (!ok) begin nMismatched++; $display("FAIL after_exhaust_timeout: no done, expected one"); end
        if (goPulses - p != 1) begin
            nMismatched++; $display("FAIL after_exhaust_go: got %0d, expected 1", goPulses - p);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int p = goPulses;
        hangMode = 1'b1;
        reqData[1] = 24'h34_0E00;
        expGrant.push_back(1);
        expDone.push_back('{1, 1'b1});
        iREQ[1] = 1'b1;
        run_until(doneCnt + 1, 1600, 1'b1, ok);
        repeat (12) @(negedge iCLK);
        hangMode = 1'b0;
        nCompared += 3;
        if (!ok) begin nMismatched++; $display("FAIL tmo_no_done: no done, expected one"); end
        if (goPulses - p != 4) begin
            nMismatched++; $display("FAIL tmo_go_pulses: got %0d, expected 4", goPulses - p);
        end
        if (lastGoTicks != 64) begin
            nMismatched++; $display("FAIL tmo_attempt_ticks: got %0d, expected 64", lastGoTicks);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit reached = 1'b0;
        int d = doneCnt;
        reqData[0] = 24'h34_1000;
        reqData[2] = 24'h34_1234;
        endTicks = 20;
        expGrant.push_back(2);
        iREQ = 3'b101;
        for (int n = 0; n < 300 && !reached; n++) begin
            @(negedge iCLK);
            if (oI2C_GO && !i2cEnd) reached = 1'b1;
        end
        repeat (12) @(negedge iCLK);
        nCompared++;
        if (!reached) begin nMismatched++; $display("FAIL mid_reach_wait_end: not reached, expected transfer running"); end
        iRST_N = 1'b0; mdlRstN = 1'b0;
        #1;
        nCompared++;
        if (oGRANT !== '0 || oDONE !== '0 || oERR !== 1'b0 || oBUSY !== 1'b0 ||
            oI2C_DATA !== '0 || oI2C_GO !== 1'b0) begin
            nMismatched++;
            $display("FAIL mid_reset_outputs: grant=%b done=%b err=%b busy=%b data=%h go=%b, expected all 0",
                     oGRANT, oDONE, oERR, oBUSY, oI2C_DATA, oI2C_GO);
        end
        repeat (4) @(negedge iCLK);
        nCompared++;
        if (doneCnt != d) begin nMismatched++; $display("FAIL mid_no_done: got %0d dones, expected %0d", doneCnt, d); end
        expGrant.push_back(0);
        expGrant.push_back(2);
        expDone.push_back('{0, 1'b0});
        expDone.push_back('{2, 1'b0});
        iRST_N = 1'b1; mdlRstN = 1'b1;
        run_until(d + 2, 800, 1'b1, ok);
        repeat (16) @(negedge iCLK);
        nCompared += 2;
        if (!ok) begin nMismatched++; $display("FAIL mid_regrant: got %0d dones, expected %0d", doneCnt, d + 2); end
        if (expGrant.size() != 0 || expDone.size() != 0) begin
            nMismatched++;
            $display("FAIL scoreboard_drain: %0d grants and %0d dones pending, expected 0/0",
                     expGrant.size(), expDone.size());
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) reqData[i] = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_nack_retry();
        test_retry_exhaust();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
